hamming_secded_stream: RTL and testbench



---
 rtl/hamming_secded_stream_if.sv | 38 +++
 rtl/hamming_secded_stream.sv | 190 +++++++++++++++++++
 tb/tb_hamming_secded_stream.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hamming_secded_stream_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hamming_secded_stream_if : stream, result and statistics bundle for the
//                            SECDED codec (master = producer/consumer side)
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface hamming_secded_stream_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  localparam int PAR_W  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : 5;
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_data;
  logic [PAR_W-1:0]  out_syndrome;
  logic [1:0]        out_err;
  logic              cnt_clr;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  modport master (
    output in_valid, in_mode, in_data, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, out_syndrome, out_err, corr_cnt, uncorr_cnt
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, out_syndrome, out_err, corr_cnt, uncorr_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hamming_secded_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hamming_secded_stream : two-stage streaming SECDED encoder/decoder with
//                         per-word mode; ERR_CNT_EN adds error counters
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module hamming_secded_stream #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  wire                     clk,
  input  wire                     rst_n,
  hamming_secded_stream_if.slave  bus
);
  localparam int PAR_W  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : 5;
  localparam int CODE_W = DATA_W + PAR_W + 1;
  localparam int DIDX_W = $clog2(DATA_W);

  // Data bits occupy the non-power-of-two positions above bit 0, d0 lowest.
  function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    logic [PAR_W-1:0]  syn;
    int                j;
    int                p;
    cw  = '0;
    syn = '0;
    j   = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos[PAR_W-1:0]] = d[j[DIDX_W-1:0]];
        if (d[j[DIDX_W-1:0]])
          syn = syn ^ pos[PAR_W-1:0];
        j++;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      p = 1 << k;
      cw[p[PAR_W-1:0]] = syn[k];
    end
    cw[0] = ^cw[CODE_W-1:1];
    return cw;
  endfunction

  function automatic logic [CODE_W-1:0] f_extract(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j[DIDX_W-1:0]] = cw[pos[PAR_W-1:0]];
        j++;
      end
    end
    return {{(CODE_W-DATA_W){1'b0}}, d};
  endfunction

  logic              r_s1_valid;
  logic              r_s1_mode;
  logic [CODE_W-1:0] r_s1_data;
  logic              r_out_valid;
  logic [CODE_W-1:0] r_out_data;
  logic [PAR_W-1:0]  r_out_syndrome;
  logic [1:0]        r_out_err;

  logic              w_s2_load;
  logic              w_in_ready;
  logic [PAR_W-1:0]  w_syn;
  logic              w_ov;
  logic              w_in_range;
  logic [CODE_W-1:0] w_flipped;
  logic [CODE_W-1:0] w_res_data;
  logic [PAR_W-1:0]  w_res_syn;
  logic [1:0]        w_res_err;

  assign w_s2_load  = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_load;

  always_comb begin
    w_syn = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (r_s1_data[pos[PAR_W-1:0]])
        w_syn = w_syn ^ pos[PAR_W-1:0];
    end
    w_ov = ^r_s1_data;
  end

  // A syndrome naming a position outside the codeword cannot be corrected.
  always_comb begin
    w_flipped  = r_s1_data;
    w_in_range = 1'b0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (int'(w_syn) == pos) begin
        w_flipped[pos[PAR_W-1:0]] = ~r_s1_data[pos[PAR_W-1:0]];
        w_in_range                = 1'b1;
      end
    end
  end

  always_comb begin
    w_res_data = '0;
    w_res_syn  = '0;
    w_res_err  = 2'b00;
    if (!r_s1_mode) begin
      w_res_data = f_encode(r_s1_data[DATA_W-1:0]);
    end else begin
      w_res_syn = w_syn;
      if (w_syn == '0) begin
        w_res_err  = w_ov ? 2'b01 : 2'b00;
        w_res_data = f_extract(r_s1_data);
      end else if (w_ov && w_in_range) begin
        w_res_err  = 2'b01;
        w_res_data = f_extract(w_flipped);
      end else begin
        w_res_err  = 2'b10;
        w_res_data = f_extract(r_s1_data);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_mode <= bus.in_mode;
        r_s1_data <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_syndrome <= '0;
      r_out_err      <= 2'b00;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data     <= w_res_data;
        r_out_syndrome <= w_res_syn;
        r_out_err      <= w_res_err;
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_syndrome = r_out_syndrome;
  assign bus.out_err      = r_out_err;

`ifdef ERR_CNT_EN
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;
  logic             w_xfer;

  assign w_xfer = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_xfer) begin
      if (r_out_err == 2'b01 && r_corr_cnt != '1)
        r_corr_cnt <= r_corr_cnt + 1'b1;
      if (r_out_err == 2'b10 && r_uncorr_cnt != '1)
        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
    end
  end

  assign bus.corr_cnt   = r_corr_cnt;
  assign bus.uncorr_cnt = r_uncorr_cnt;
`else
  logic w_unused;
  assign w_unused       = bus.cnt_clr;
  assign bus.corr_cnt   = '0;
  assign bus.uncorr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_hamming_secded_stream : directed bench for the SECDED stream codec,
//                            DATA_W=4 / CNT_W=2, either ERR_CNT_EN build
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_hamming_secded_stream;
`ifdef ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   m_corr = 0;
  int   m_uncorr = 0;

  always #5 clk = ~clk;

  hamming_secded_stream_if #(.DATA_W(4), .CNT_W(2)) bus ();

  hamming_secded_stream #(.DATA_W(4), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_xfer(input logic [1:0] err, input logic clr);
    if (clr) begin
      m_corr   = 0;
      m_uncorr = 0;
    end else if (err == 2'b01 && m_corr != 3) begin
      m_corr++;
    end else if (err == 2'b10 && m_uncorr != 3) begin
      m_uncorr++;
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "/corr"},   bus.corr_cnt,   CNT_ON ? m_corr   : 0);
    chk({tag, "/uncorr"}, bus.uncorr_cnt, CNT_ON ? m_uncorr : 0);
  endtask

  // Called at a falling edge with the pipeline empty; checks exact 2-cycle latency.
  task automatic run_one(input string tag, input logic mode, input logic [7:0] din,
                         input logic [7:0] exp_d, input logic [2:0] exp_s,
                         input logic [1:0] exp_e, input logic clr);
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_data   = din;
    bus.out_ready = 1'b1;
    #1 chk({tag, "/in_ready"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "/early"}, bus.out_valid, 0);
    @(negedge clk);
    chk({tag, "/valid"}, bus.out_valid, 1);
    chk({tag, "/data"},  bus.out_data, exp_d);
    chk({tag, "/syn"},   bus.out_syndrome, exp_s);
    chk({tag, "/err"},   bus.out_err, exp_e);
    bus.cnt_clr = clr;
    model_xfer(exp_e, clr);
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    chk_cnt(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  bp_din [4];
    logic        bp_mode[4];
    logic [12:0] bp_exp [4];
    int          idx;
    int          k;

    bp_din[0] = 8'h05; bp_mode[0] = 1'b0; bp_exp[0] = {8'h5A, 3'd0, 2'b00};
    bp_din[1] = 8'hAA; bp_mode[1] = 1'b1; bp_exp[1] = {8'h0B, 3'd0, 2'b00};
    bp_din[2] = 8'h0F; bp_mode[2] = 1'b0; bp_exp[2] = {8'hFF, 3'd0, 2'b00};
    bp_din[3] = 8'h8A; bp_mode[3] = 1'b1; bp_exp[3] = {8'h0B, 3'd5, 2'b01};

    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.cnt_clr   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst/valid", bus.out_valid, 0);
    chk("rst/data",  bus.out_data, 0);
    chk("rst/syn",   bus.out_syndrome, 0);
    chk("rst/err",   bus.out_err, 0);
    chk("rst/ready", bus.in_ready, 1);
    chk_cnt("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run_one("enc0B",  1'b0, 8'h0B, 8'hAA, 3'd0, 2'b00, 1'b0);
    run_one("decAA",  1'b1, 8'hAA, 8'h0B, 3'd0, 2'b00, 1'b0);
    run_one("dec8A",  1'b1, 8'h8A, 8'h0B, 3'd5, 2'b01, 1'b0);
    run_one("decAB",  1'b1, 8'hAB, 8'h0B, 3'd0, 2'b01, 1'b0);
    run_one("decCA",  1'b1, 8'hCA, 8'h0D, 3'd3, 2'b10, 1'b0);

    // Backpressure: downstream stalls for the first five cycles.
    idx = 0;
    k   = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (idx < 4);
      if (idx < 4) begin
        bus.in_mode = bp_mode[idx];
        bus.in_data = bp_din[idx];
      end
      #1;
      if (cyc < 2)
        chk("bp/ready_open", bus.in_ready, 1);
      if (cyc >= 2 && cyc <= 4) begin
        chk("bp/ready_stall", bus.in_ready, 0);
        chk("bp/valid_stall", bus.out_valid, 1);
        chk("bp/data_stall",  {bus.out_data, bus.out_syndrome, bus.out_err}, bp_exp[0]);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("bp/result", {bus.out_data, bus.out_syndrome, bus.out_err}, bp_exp[k]);
        model_xfer(bus.out_err, 1'b0);
        k++;
      end
      if (bus.in_valid && bus.in_ready)
        idx++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("bp/count", k, 4);
    chk("bp/no_dup", bus.out_valid, 0);
    repeat (2) @(negedge clk);
    chk("bp/idle", bus.out_valid, 0);
    chk_cnt("bp");

    bus.cnt_clr = 1'b1;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    model_xfer(2'b00, 1'b1);
    chk_cnt("clr");

    for (int i = 0; i < 5; i++)
      run_one("sat", 1'b1, 8'h8A, 8'h0B, 3'd5, 2'b01, 1'b0);
    run_one("clr_vs_inc", 1'b1, 8'h8A, 8'h0B, 3'd5, 2'b01, 1'b1);
    run_one("decCA2",     1'b1, 8'hCA, 8'h0D, 3'd3, 2'b10, 1'b0);

    // Asynchronous reset with two words in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 1'b0;
    bus.in_data   = 8'h0B;
    @(negedge clk);
    bus.in_mode = 1'b1;
    bus.in_data = 8'h8A;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid/inflight", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    model_xfer(2'b00, 1'b1);
    chk("mid/valid", bus.out_valid, 0);
    chk("mid/data",  bus.out_data, 0);
    chk("mid/syn",   bus.out_syndrome, 0);
    chk("mid/err",   bus.out_err, 0);
    chk("mid/ready", bus.in_ready, 1);
    chk_cnt("mid");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid/quiet", bus.out_valid, 0);
    end
    chk("mid/ready_after", bus.in_ready, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
